// File: rtl/rr_mux_collector.sv
// ============================================================================
// rr_mux_collector
// ----------------------------------------------------------------------------
// Purpose:
//   Fan-in collector that merges 2**SELECT_WIDTH producer lanes onto a single
//   registered output stream. Each lane offers words with a valid/ready
//   handshake. A round-robin arbiter grants at most one lane per cycle. The
//   granted word and its source lane index are captured in a one-word output
//   slot that is drained with out_valid/out_ready. In the maze system this
//   funnels cell-update words from the parallel walker units into the single
//   maze-memory write port.
//
// Parameters:
//   WIDTH         data word width in bits
//   SELECT_WIDTH  lane index width; lane count N = 2**SELECT_WIDTH
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (synchronous release)
//   in_valid   in   [N]          lane i offers a word
//   in_data    in   [WIDTH] x N  lane i word (unpacked array)
//   in_ready   out  [N]          lane i word accepted this cycle (one-hot or 0)
//   out_valid  out               out_data/out_index hold a valid word
//   out_data   out  [WIDTH]      collected word
//   out_index  out  [SELECT_WIDTH] source lane of out_data
//   out_ready  in                consumer takes the word this cycle
//
// Configuration macro:
//   MUX_FIXED_PRIORITY_EN  when defined, the lowest-numbered valid lane always
//                          wins and the round-robin pointer is removed. Higher
//                          lanes may starve. Handshake, latency and reset
//                          behaviour are identical to the default build.
// ============================================================================
module rr_mux_collector #(
    parameter int WIDTH        = 8,
    parameter int SELECT_WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [(1<<SELECT_WIDTH)-1:0]  in_valid,
    input  logic [WIDTH-1:0]              in_data [(1<<SELECT_WIDTH)],
    output logic [(1<<SELECT_WIDTH)-1:0]  in_ready,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    output logic [SELECT_WIDTH-1:0]       out_index,
    input  logic                          out_ready
);

    localparam int N = 1 << SELECT_WIDTH;

    logic                    grant_vld;
    logic [SELECT_WIDTH-1:0] grant_idx;
    logic [SELECT_WIDTH-1:0] cand;
    logic                    can_load;
    logic                    load;

`ifndef MUX_FIXED_PRIORITY_EN
    // Lane that has highest priority next; advances past each granted lane.
    logic [SELECT_WIDTH-1:0] ptr;
`endif

    // ------------------------------------------------------------------
    // Arbitration: first valid lane at or after the start lane, with wrap.
    // The index arithmetic is SELECT_WIDTH bits wide, so the modulo-N wrap
    // falls out of the natural overflow.
    // ------------------------------------------------------------------
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
`ifdef MUX_FIXED_PRIORITY_EN
            cand = SELECT_WIDTH'(k);
`else
            cand = ptr + SELECT_WIDTH'(k);
`endif
            if (!grant_vld && in_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // The slot can take a new word when it is empty or being drained now,
    // which gives back-to-back loading at one word per cycle.
    assign can_load = !out_valid || out_ready;
    assign load     = grant_vld && can_load;

    always_comb begin
        in_ready = '0;
        if (load) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output slot register: the only path from in_data to out_data.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data[grant_idx];
            out_index <= grant_idx;
        end else if (out_ready) begin
            // Drain with nothing to load: data and index keep last values.
            out_valid <= 1'b0;
        end
    end

`ifndef MUX_FIXED_PRIORITY_EN
    // Pointer moves only on a transfer, so idle and stalled cycles keep
    // the current priority order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= grant_idx + SELECT_WIDTH'(1);
        end
    end
`endif

endmodule
